// File: rtl/prng_pkg.sv
// Shared types and constants for the LFSR PRNG sequencing controller.
package prng_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] SAFE_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned base_hz);
        return clk_hz / base_hz;
    endfunction

endpackage

// File: rtl/prng_tick_gen.sv
// Prescaler producing a single-cycle tick every (TICK_DIV << rate_sel) enabled cycles.
module prng_tick_gen
    import prng_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10,
    parameter int          CNT_W    = $clog2(TICK_DIV << 7)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] rate_sel,
    output logic       tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term_q, term_d;

    function automatic logic [CNT_W-1:0] term_of(input logic [2:0] r);
        return CNT_W'((TICK_DIV << r) - 1);
    endfunction

    // The terminal count is latched only at clear or wrap, so a rate change
    // never truncates or stretches the interval already in progress.
    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        tick   = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            term_d = term_of(rate_sel);
        end else if (en) begin
            if (cnt_q == term_q) begin
                tick   = 1'b1;
                cnt_d  = '0;
                term_d = term_of(rate_sel);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= term_of(3'd0);
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/prng_seq_ctrl.sv
// Sequencer for the LFSR PRNG: seed load, paced or on-demand stepping, and
// valid/ready delivery of 8-bit samples.
module prng_seq_ctrl
    import prng_pkg::*;
#(
    parameter int unsigned      CLK_HZ    = 10_000_000,
    parameter int unsigned      BASE_HZ   = 1_000,
    parameter int               WIDTH     = prng_pkg::WIDTH,
    parameter logic [WIDTH-1:0] SAFE_SEED = prng_pkg::SAFE_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             seed_we,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [2:0]       rate_sel,
    input  logic             req,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_step,
    output logic [7:0]       sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, BASE_HZ);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [7:0]       data_q, data_d;
    logic             cap_q, cap_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic             overrun_q, overrun_d;
    logic             tick, tg_en, tg_clr;
    logic             do_step, do_load;
    logic             unused_hi;

    assign tg_en  = ena && !mode && (state_q == RUN || state_q == HOLD);
    assign tg_clr = ena && (state_q == SEED);

    prng_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tg_clr),
        .en       (tg_en),
        .rate_sel (rate_sel),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cap_d     = cap_q;
        valid_d   = valid_q;
        req_d     = req_q;
        overrun_d = overrun_q;
        do_step   = 1'b0;
        do_load   = 1'b0;
        seed_d    = seed_q;
        if (seed_we) begin
            seed_d = (seed_in == '0) ? SAFE_SEED : seed_in;
        end
        if (ena) begin
            req_d = 1'b0;
            if (start) overrun_d = 1'b0;
            // The LFSR only moves on our strobe, so the post-step value is
            // frozen into the holding register one cycle after the step.
            if (cap_q) begin
                data_d = lfsr_q[7:0];
                cap_d  = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) state_d = SEED;
                end
                SEED: begin
                    do_load = 1'b1;
                    state_d = stop ? IDLE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else begin
                        do_step = mode ? req_q : tick;
                        if (do_step) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                            cap_d   = 1'b1;
                        end else if (mode && req) begin
                            req_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!mode && tick) overrun_d = 1'b1;
                    if (stop || sample_ready) begin
                        state_d = stop ? IDLE : RUN;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seed_q    <= SAFE_SEED;
            data_q    <= '0;
            cap_q     <= 1'b0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            data_q    <= data_d;
            cap_q     <= cap_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            overrun_q <= overrun_d;
        end
    end

    assign lfsr_load    = do_load;
    assign lfsr_step    = do_step;
    assign lfsr_seed    = seed_q;
    assign sample_data  = cap_q ? lfsr_q[7:0] : data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign state_o      = state_q;
    assign unused_hi    = ^lfsr_q[WIDTH-1:8];

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Directed bench for prng_seq_ctrl with a small LFSR model driving lfsr_q.
module tb_prng_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] seed_in;
    logic        seed_we;
    logic        start;
    logic        stop;
    logic        mode;
    logic [2:0]  rate_sel;
    logic        req;
    logic [15:0] lfsr_m;
    logic        lfsr_load;
    logic [15:0] lfsr_seed;
    logic        lfsr_step;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prng_seq_ctrl #(
        .CLK_HZ  (1000),
        .BASE_HZ (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .seed_in      (seed_in),
        .seed_we      (seed_we),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .rate_sel     (rate_sel),
        .req          (req),
        .lfsr_q       (lfsr_m),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_step    (lfsr_step),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .state_o      (state_o)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lfsr_m <= '0;
        else if (lfsr_load) lfsr_m <= lfsr_seed;
        else if (lfsr_step) lfsr_m <= lfsr_next(lfsr_m);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every step must be followed one cycle later by a valid sample holding
    // the low byte of the freshly stepped LFSR state.
    logic step_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && step_prev) begin
            check("step_to_valid", sample_valid, 1);
            check("step_data", sample_data, lfsr_m[7:0]);
        end
        step_prev <= rst_n && lfsr_step;
    end

    task automatic wait_step(input string tag, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lfsr_step && n < max);
        if (!lfsr_step) check({tag, "_timeout"}, lfsr_step, 1);
    endtask

    initial begin
        int n;
        int steps;
        int loads;
        int bad;
        logic [7:0] exp_d;

        rst_n = 1'b0; ena = 1'b0; seed_in = '0; seed_we = 1'b0; start = 1'b0;
        stop = 1'b0; mode = 1'b0; rate_sel = 3'd0; req = 1'b0; sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_step", lfsr_step, 0);
        check("rst_load", lfsr_load, 0);
        check("rst_seed", lfsr_seed, 16'hACE1);
        check("rst_data", sample_data, 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Zero seed written after a non-zero one must become the safe seed.
        seed_in = 16'h1234; seed_we = 1'b1;
        @(negedge clk);
        seed_in = 16'h0000;
        @(negedge clk);
        seed_we = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_state_seed", state_o, 1);
        check("t1_load", lfsr_load, 1);
        check("t1_seed_safe", lfsr_seed, 16'hACE1);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_state_run", state_o, 2);
        check("t1_load_once", lfsr_load, 0);

        // Free-run, rate 0: ten-cycle step period.
        wait_step("t2_first", 50, n);
        check("t2_first_gap", n, 9);
        repeat (2) begin
            wait_step("t2_gap", 50, n);
            check("t2_gap", n, 10);
        end

        // Rate 2 (40 cycles), then switch to rate 1 mid-interval.
        rate_sel = 3'd2;
        @(negedge clk);
        check("t2_hold", state_o, 3);
        @(negedge clk);
        check("t2_rearm_state", state_o, 2);
        check("t2_rearm_valid", sample_valid, 0);
        wait_step("t3_r2", 100, n);
        check("t3_r2_gap", n, 38);
        repeat (15) @(negedge clk);
        rate_sel = 3'd1;
        wait_step("t3_pending", 100, n);
        check("t3_pending_gap", n, 25);
        wait_step("t3_r1a", 100, n);
        check("t3_r1a_gap", n, 20);
        wait_step("t3_r1b", 100, n);
        check("t3_r1b_gap", n, 20);

        // On-demand mode with a stalled consumer.
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_stop_idle", state_o, 0);
        check("t4_stop_busy", busy, 0);
        mode = 1'b1; sample_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t4_run", state_o, 2);
        req = 1'b1;
        #1;
        check("t4_req_same_cycle", lfsr_step, 0);
        @(negedge clk);
        req = 1'b0;
        check("t4_step_p1", lfsr_step, 1);
        @(negedge clk);
        check("t4_valid_p2", sample_valid, 1);
        check("t4_hold", state_o, 3);
        exp_d = lfsr_m[7:0];
        steps = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            req = (i % 5 == 0);
            @(negedge clk);
            if (lfsr_step) steps++;
            if (sample_data !== exp_d || sample_valid !== 1'b1) bad++;
        end
        req = 1'b0;
        check("t4_hold_steps", steps, 0);
        check("t4_hold_stable", bad, 0);
        check("t4_hold_state", state_o, 3);
        sample_ready = 1'b1;
        @(negedge clk);
        check("t4_release_valid", sample_valid, 0);
        check("t4_release_state", state_o, 2);
        steps = 0;
        repeat (3) begin
            @(negedge clk);
            if (lfsr_step) steps++;
        end
        check("t4_no_stale_req", steps, 0);

        // Free-run overrun: ticks while a sample is pending are dropped.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_idle", state_o, 0);
        mode = 1'b0; rate_sel = 3'd0; sample_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_overrun_clear", dut.overrun_q, 0);
        wait_step("t5_first", 50, n);
        check("t5_first_gap", n, 9);
        steps = 0;
        repeat (35) begin
            @(negedge clk);
            if (lfsr_step) steps++;
        end
        check("t5_dropped", steps, 0);
        check("t5_hold", state_o, 3);
        check("t5_valid", sample_valid, 1);
        check("t5_overrun", dut.overrun_q, 1);
        sample_ready = 1'b1;
        wait_step("t5_resume", 50, n);
        check("t5_resume_gap", n, 5);

        // Stop while a sample is held.
        sample_ready = 1'b0;
        @(negedge clk);
        check("t6_hold", state_o, 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t6_stop_state", state_o, 0);
        check("t6_stop_valid", sample_valid, 0);
        check("t6_stop_busy", busy, 0);
        steps = 0; loads = 0;
        repeat (30) begin
            @(negedge clk);
            if (lfsr_step) steps++;
            if (lfsr_load) loads++;
        end
        check("t6_idle_steps", steps, 0);
        check("t6_idle_loads", loads, 0);

        // New seed, restart, then asynchronous reset in the middle of RUN.
        seed_in = 16'hBEEF; seed_we = 1'b1;
        @(negedge clk);
        seed_we = 1'b0; sample_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_seed_state", state_o, 1);
        check("t6_seed_new", lfsr_seed, 16'hBEEF);
        check("t6_seed_load", lfsr_load, 1);
        check("t6_overrun_cleared", dut.overrun_q, 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("t6_pre_rst_state", state_o, 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", state_o, 0);
        check("t6_rst_valid", sample_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_seed", lfsr_seed, 16'hACE1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        steps = 0; loads = 0;
        repeat (100) begin
            @(negedge clk);
            if (lfsr_step) steps++;
            if (lfsr_load) loads++;
        end
        check("t6_post_rst_steps", steps, 0);
        check("t6_post_rst_loads", loads, 0);
        check("t6_post_rst_state", state_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prng_seq_ctrl.md
Name: prng_seq_ctrl

Overview:
Controller that sequences the 16-bit LFSR PRNG datapath inside tt_um_top.
- Loads and sanitises the seed, paces LFSR stepping from a prescaled tick derived from the top-level clock-frequency parameter, and supports free-run or on-demand stepping.
- Presents 8-bit samples to a consumer through a valid/ready handshake.
- Sits between the pin-decode logic (ui_in/uio_in) and the LFSR core.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz.
- BASE_HZ, 1_000, base tick rate in Hz; TICK_DIV = CLK_HZ/BASE_HZ, must be >= 2.
- WIDTH, 16, LFSR state width.
- SAFE_SEED, 16'hACE1, value substituted when a zero seed is written.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, design enable; when low, tick counters and FSM hold.
- seed_in, input, 16, seed value.
- seed_we, input, 1, one-cycle seed write strobe.
- start, input, 1, pulse: begin operation.
- stop, input, 1, pulse: return to IDLE.
- mode, input, 1, 0 = free-run, 1 = on-demand.
- rate_sel, input, 3, step period = TICK_DIV << rate_sel cycles (free-run only).
- req, input, 1, on-demand step request pulse.
- lfsr_q, input, 16, current LFSR state.
- lfsr_load, output, 1, one-cycle load strobe to LFSR.
- lfsr_seed, output, 16, value to load.
- lfsr_step, output, 1, one-cycle advance strobe.
- sample_data, output, 8, held sample (lfsr_q[7:0] captured after the step).
- sample_valid, output, 1, sample available.
- sample_ready, input, 1, consumer accepts.
- busy, output, 1, high in any state except IDLE.
- state_o, output, 2, FSM state for debug (IDLE=0, SEED=1, RUN=2, HOLD=3).

Behaviour:
- Reset: async on rst_n low. All outputs 0; lfsr_seed = SAFE_SEED; internal seed register = SAFE_SEED; FSM = IDLE; prescaler = 0.
- Seed register:
  - seed_we captures seed_in; a zero value stores SAFE_SEED instead.
  - seed_we is accepted in any state and takes effect at the next SEED entry.
- IDLE:
  - start (with ena) -> SEED.
  - stop, req and ticks are ignored.
- SEED:
  - Exactly one cycle; lfsr_load = 1 and lfsr_seed = seed register.
  - Next state RUN; prescaler cleared.
- RUN, free-run:
  - Prescaler counts enabled cycles; on reaching (TICK_DIV << rate_sel) - 1 it wraps to 0 and asserts lfsr_step for one cycle.
  - rate_sel changes take effect at the next wrap.
- RUN, on-demand: req asserts lfsr_step in the following cycle; the prescaler is idle.
- Step -> sample:
  - Cycle after lfsr_step: sample_data <= lfsr_q[7:0], sample_valid <= 1, FSM -> HOLD.
  - Step-to-valid latency is 1 cycle; req-to-valid latency is 2 cycles.
- HOLD:
  - sample_data is stable while sample_valid is high.
  - When sample_valid && sample_ready: sample_valid clears the next cycle and FSM -> RUN.
  - Free-run: the prescaler keeps counting in HOLD. A tick that occurs while a sample is pending is dropped (no lfsr_step) and a sticky internal overrun flag is set; the flag clears on start.
  - On-demand: req while in HOLD is ignored.
- stop:
  - Accepted in SEED, RUN or HOLD; next state IDLE, sample_valid cleared, no further strobes.
  - stop in the same cycle as start while in IDLE: start wins.
  - stop in the same cycle as a tick: no step is issued.
- ena low: FSM, prescaler and sample registers hold; lfsr_step and lfsr_load are forced to 0.
- Mid-operation reset: everything returns to reset values immediately; no strobes are emitted during or after reset.
- Arithmetic:
  - Prescaler width = clog2(TICK_DIV << 7).
  - Compare is unsigned; no overflow because the count wraps to 0 at the terminal value.

Decomposition:
- Package prng_pkg:
  - state enum (IDLE, SEED, RUN, HOLD);
  - SAFE_SEED constant;
  - WIDTH;
  - function tick_div(CLK_HZ, BASE_HZ).
- One sub-module, prng_tick_gen: prescaler with clr, en and rate_sel inputs; single-cycle tick output.

Test Plan:
Bench parameters: CLK_HZ = 1000, BASE_HZ = 100 (TICK_DIV = 10).
1. Reset, seed_we with 16'h0000, then start -> SEED cycle shows lfsr_load = 1 and lfsr_seed = 16'hACE1; state sequence 0 -> 1 -> 2.
2. Free-run, rate_sel = 0, sample_ready tied high -> lfsr_step every 10 cycles; sample_valid 1 cycle after each step; sample_data = low byte of lfsr_q.
3. rate_sel = 2 -> steps every 40 cycles; change rate_sel to 1 mid-count -> next interval still 40, subsequent intervals 20.
4. On-demand mode, req pulse -> lfsr_step at +1 and sample_valid at +2; sample_ready held low for 50 cycles -> sample_data stable and extra req pulses ignored.
5. Free-run with sample_ready low across 3 ticks -> no lfsr_step issued; overrun flag set; after sample_ready, steps resume on the next tick.
6. Assert stop during HOLD; separately, pulse rst_n low mid-RUN -> state_o = 0, sample_valid = 0, and no lfsr_step or lfsr_load for 100 cycles.
